mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache masters, the arbiter and the memory port.
// The arbiter uses the slave modport; the master modport is the cache/memory side.
interface mem_arbiter_if #(
    parameter int AddrBusWidth = 32,
    parameter int MemBusWidth  = 32
);
    localparam int SelW = MemBusWidth / 8;

    // Handshake: a master request is taken at a rising edge where mN_ready and
    // (mN_re | mN_we) are both 1; a memory request is taken at a rising edge
    // where (mem_re | mem_we) and mem_ready are both 1; mN_r_data_valid and
    // mem_r_data_valid are single-cycle qualifiers with no back-pressure.
    logic [AddrBusWidth-1:0] m0_addr,   m1_addr;
    logic [MemBusWidth-1:0]  m0_w_data, m1_w_data;
    logic [SelW-1:0]         m0_w_sel,  m1_w_sel;
    logic                    m0_re, m0_we, m1_re, m1_we;
    logic                    m0_ready, m1_ready;
    logic [MemBusWidth-1:0]  m0_r_data, m1_r_data;
    logic                    m0_r_data_valid, m1_r_data_valid;

    logic [AddrBusWidth-1:0] mem_addr;
    logic [MemBusWidth-1:0]  mem_w_data;
    logic [SelW-1:0]         mem_w_sel;
    logic                    mem_re, mem_we;
    logic                    mem_ready;
    logic [MemBusWidth-1:0]  mem_r_data;
    logic                    mem_r_data_valid;

    // Debug view of the arbiter FSM: 0 = IDLE, 1 = ISSUE, 2 = WAIT_RD.
    logic [1:0]              state_dbg;

    modport slave (
        input  m0_addr, m0_w_data, m0_w_sel, m0_re, m0_we,
        input  m1_addr, m1_w_data, m1_w_sel, m1_re, m1_we,
        output m0_ready, m0_r_data, m0_r_data_valid,
        output m1_ready, m1_r_data, m1_r_data_valid,
        output mem_addr, mem_w_data, mem_w_sel, mem_re, mem_we,
        input  mem_ready, mem_r_data, mem_r_data_valid,
        output state_dbg
    );

    modport master (
        output m0_addr, m0_w_data, m0_w_sel, m0_re, m0_we,
        output m1_addr, m1_w_data, m1_w_sel, m1_re, m1_we,
        input  m0_ready, m0_r_data, m0_r_data_valid,
        input  m1_ready, m1_r_data, m1_r_data_valid,
        input  mem_addr, mem_w_data, mem_w_sel, mem_re, mem_we,
        output mem_ready, mem_r_data, mem_r_data_valid,
        input  state_dbg
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (icache = 0, dcache = 1) round-robin arbiter onto one memory port,
// with one pending request slot per master and one outstanding read at a time.
module mem_arbiter #(
    parameter int AddrBusWidth = 32,
    parameter int MemBusWidth  = 32
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int SelW = MemBusWidth / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]              pend;
    logic [1:0]              slot_wr;
    logic [AddrBusWidth-1:0] slot_addr  [2];
    logic [MemBusWidth-1:0]  slot_wdata [2];
    logic [SelW-1:0]         slot_wsel  [2];
    logic                    grant, last_grant;
    logic                    sel, drive, accept;
    logic [MemBusWidth-1:0]  r_data [2];
    logic [1:0]              r_valid;

    logic [AddrBusWidth-1:0] req_addr  [2];
    logic [MemBusWidth-1:0]  req_wdata [2];
    logic [SelW-1:0]         req_wsel  [2];
    logic [1:0]              req_re, req_we;

    assign req_addr[0]  = bus.m0_addr;
    assign req_addr[1]  = bus.m1_addr;
    assign req_wdata[0] = bus.m0_w_data;
    assign req_wdata[1] = bus.m1_w_data;
    assign req_wsel[0]  = bus.m0_w_sel;
    assign req_wsel[1]  = bus.m1_w_sel;
    assign req_re       = {bus.m1_re, bus.m0_re};
    assign req_we       = {bus.m1_we, bus.m0_we};

    // A master is ready exactly when its slot is empty.
    assign bus.m0_ready        = ~pend[0];
    assign bus.m1_ready        = ~pend[1];
    assign bus.m0_r_data       = r_data[0];
    assign bus.m1_r_data       = r_data[1];
    assign bus.m0_r_data_valid = r_valid[0];
    assign bus.m1_r_data_valid = r_valid[1];
    assign bus.state_dbg       = state;

    always_comb begin
        sel       = grant;
        drive     = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                sel   = (pend == 2'b11) ? ~last_grant : pend[1];
                drive = |pend;
            end
            ISSUE:   drive = 1'b1;
            WAIT_RD: if (bus.mem_r_data_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        accept = drive & bus.mem_ready;
        if (drive) begin
            if (!accept)          state_nxt = ISSUE;
            else if (slot_wr[sel]) state_nxt = IDLE;
            else                  state_nxt = WAIT_RD;
        end
    end

    // The memory bus is zeroed whenever no request is being presented.
    always_comb begin
        bus.mem_re     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_w_data = '0;
        bus.mem_w_sel  = '0;
        if (drive) begin
            bus.mem_re     = ~slot_wr[sel];
            bus.mem_we     = slot_wr[sel];
            bus.mem_addr   = slot_addr[sel];
            bus.mem_w_data = slot_wdata[sel];
            bus.mem_w_sel  = slot_wsel[sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pend       <= 2'b00;
            slot_wr    <= 2'b00;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            r_valid    <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                slot_addr[n]  <= '0;
                slot_wdata[n] <= '0;
                slot_wsel[n]  <= '0;
                r_data[n]     <= '0;
            end
        end else begin
            state   <= state_nxt;
            r_valid <= 2'b00;
            if (state == IDLE && drive) grant <= sel;
            if (accept) begin
                last_grant <= sel;
                if (slot_wr[sel]) pend[sel] <= 1'b0;
            end
            if (state == WAIT_RD && bus.mem_r_data_valid) begin
                r_data[grant]  <= bus.mem_r_data;
                r_valid[grant] <= 1'b1;
                pend[grant]    <= 1'b0;
            end
            // Capture only touches empty slots, so it never races the clears above.
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && (req_re[n] || req_we[n])) begin
                    pend[n]       <= 1'b1;
                    slot_wr[n]    <= req_we[n] & ~req_re[n];
                    slot_addr[n]  <= req_addr[n];
                    slot_wdata[n] <= req_wdata[n];
                    slot_wsel[n]  <= req_wsel[n];
                end
            end
        end
    end
endmodule
